tri_fifo_writer: RTL and testbench

- Producer side of the vertex/color FIFO pair. The downstream triangle assembler pops three vertex/color pairs from these FIFOs to build one triangle.
- Accepts one whole triangle per handshake: 3 vertices and 3 colors, each DATA_W bits.
- Serialises the triangle into the vertex FIFO and the color FIFO in lock-step, one vertex/color pair per write beat, in order 0, 1, 2.
- Both FIFOs always receive identical write counts, so the reader's pairing of vertex k with color k is preserved.

---
 rtl/rast_fifo_pkg.sv | 20 ++
 rtl/tri_fifo_writer.sv | 108 ++++++++++
 tb/tb_tri_fifo_writer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rast_fifo_pkg.sv
// rtl/rast_fifo_pkg.sv - shared definitions for the rasteriser vertex/color FIFO pair
// Holds the default word width shared by the FIFO writer and reader, the
// writer state encoding and the number of vertices per triangle.
package rast_fifo_pkg;

  // Width of one vertex word and one color word; the reader uses the same value.
  localparam int DEFAULT_DATA_W = 96;

  // Vertex/color pairs written per triangle.
  localparam int VERTS_PER_TRI = 3;

  // Writer states: idle, then one state per vertex/color beat.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2,
    WR2  = 2'd3
  } wr_state_t;

endpackage

// File: rtl/tri_fifo_writer.sv
// rtl/tri_fifo_writer.sv - serialises one triangle into the vertex and color FIFOs in lock-step
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   tri_valid / tri_ready        triangle handshake (one whole triangle per transfer)
//   vertex_in0..2, color_in0..2  triangle vertices and colors
//   vertex_full, color_full      FIFO full flags
//   vertex_wr_en, color_wr_en    FIFO write strobes (always equal)
//   vertex_dout, color_dout      FIFO write data
//   busy                         a captured triangle is still being written
//   tri_count                    completed triangles, wraps
module tri_fifo_writer
  import rast_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tri_valid,
  output logic              tri_ready,
  input  logic [DATA_W-1:0] vertex_in0,
  input  logic [DATA_W-1:0] vertex_in1,
  input  logic [DATA_W-1:0] vertex_in2,
  input  logic [DATA_W-1:0] color_in0,
  input  logic [DATA_W-1:0] color_in1,
  input  logic [DATA_W-1:0] color_in2,
  input  logic              vertex_full,
  input  logic              color_full,
  output logic              vertex_wr_en,
  output logic              color_wr_en,
  output logic [DATA_W-1:0] vertex_dout,
  output logic [DATA_W-1:0] color_dout,
  output logic              busy,
  output logic [CNT_W-1:0]  tri_count
);

  wr_state_t         state;
  logic [DATA_W-1:0] cap_v0, cap_v1, cap_v2;
  logic [DATA_W-1:0] cap_c0, cap_c1, cap_c2;
  logic              go;

  // Either FIFO being full stalls both so their write counts never diverge.
  assign go = !vertex_full && !color_full;

  // Ready is held low while reset is asserted even though the state is already IDLE.
  assign tri_ready    = (state == IDLE) && !rst;
  assign busy         = (state != IDLE);
  assign vertex_wr_en = busy && go;
  assign color_wr_en  = busy && go;

  // The mux falls through to beat 2 in IDLE: that is the last beat driven,
  // and the capture registers are zero after reset.
  always_comb begin
    vertex_dout = cap_v2;
    color_dout  = cap_c2;
    case (state)
      WR0: begin
        vertex_dout = cap_v0;
        color_dout  = cap_c0;
      end
      WR1: begin
        vertex_dout = cap_v1;
        color_dout  = cap_c1;
      end
      default: begin
        vertex_dout = cap_v2;
        color_dout  = cap_c2;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cap_v0    <= '0;
      cap_v1    <= '0;
      cap_v2    <= '0;
      cap_c0    <= '0;
      cap_c1    <= '0;
      cap_c2    <= '0;
      tri_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tri_valid) begin
            cap_v0 <= vertex_in0;
            cap_v1 <= vertex_in1;
            cap_v2 <= vertex_in2;
            cap_c0 <= color_in0;
            cap_c1 <= color_in1;
            cap_c2 <= color_in2;
            state  <= WR0;
          end
        end
        WR0: if (go) state <= WR1;
        WR1: if (go) state <= WR2;
        WR2: begin
          if (go) begin
            state     <= IDLE;
            tri_count <= tri_count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_fifo_writer.sv
// tb/tb_tri_fifo_writer.sv - self-checking bench for tri_fifo_writer
module tb_tri_fifo_writer;

  localparam int DW = 96;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tri_valid = 1'b0;
  logic [DW-1:0] vertex_in0 = '0, vertex_in1 = '0, vertex_in2 = '0;
  logic [DW-1:0] color_in0 = '0, color_in1 = '0, color_in2 = '0;
  logic          vertex_full = 1'b0, color_full = 1'b0;

  logic          tri_ready, vertex_wr_en, color_wr_en, busy;
  logic [DW-1:0] vertex_dout, color_dout;
  logic [15:0]   tri_count;

  logic          w_ready, w_vwe, w_cwe, w_busy;
  logic [DW-1:0] w_vdout, w_cdout;
  logic [1:0]    w_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int strobe_split = 0;

  logic [DW-1:0] exp_v[$], exp_c[$], obs_v[$], obs_c[$];
  int            obs_cyc[$];

  tri_fifo_writer #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .vertex_in0(vertex_in0), .vertex_in1(vertex_in1), .vertex_in2(vertex_in2),
    .color_in0(color_in0), .color_in1(color_in1), .color_in2(color_in2),
    .vertex_full(vertex_full), .color_full(color_full),
    .vertex_wr_en(vertex_wr_en), .color_wr_en(color_wr_en),
    .vertex_dout(vertex_dout), .color_dout(color_dout),
    .busy(busy), .tri_count(tri_count)
  );

  // Second instance with a 2-bit counter, driven identically, for the wrap check.
  tri_fifo_writer #(.DATA_W(DW), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(w_ready),
    .vertex_in0(vertex_in0), .vertex_in1(vertex_in1), .vertex_in2(vertex_in2),
    .color_in0(color_in0), .color_in1(color_in1), .color_in2(color_in2),
    .vertex_full(vertex_full), .color_full(color_full),
    .vertex_wr_en(w_vwe), .color_wr_en(w_cwe),
    .vertex_dout(w_vdout), .color_dout(w_cdout),
    .busy(w_busy), .tri_count(w_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every write beat seen by the FIFOs, mid-cycle.
  always @(negedge clk) begin
    if (vertex_wr_en || color_wr_en) begin
      obs_v.push_back(vertex_dout);
      obs_c.push_back(color_dout);
      obs_cyc.push_back(cyc);
      if (vertex_wr_en !== color_wr_en) strobe_split++;
    end
  end

  task automatic clear_sb();
    exp_v.delete(); exp_c.delete(); obs_v.delete(); obs_c.delete(); obs_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for tri_ready, presents one triangle, returns 1 time unit after the accept edge.
  task automatic send_tri(input logic [DW-1:0] v0, v1, v2, c0, c1, c2);
    int n = 0;
    while (!tri_ready && n < 100) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (tri_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_ready_timeout tri_ready=%0b required 1", tri_ready);
    end
    vertex_in0 = v0; vertex_in1 = v1; vertex_in2 = v2;
    color_in0 = c0; color_in1 = c1; color_in2 = c2;
    exp_v.push_back(v0); exp_v.push_back(v1); exp_v.push_back(v2);
    exp_c.push_back(c0); exp_c.push_back(c1); exp_c.push_back(c2);
    tri_valid = 1'b1;
    @(posedge clk); #1;
    tri_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!tri_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_sb();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (tri_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_in_rst got=%0b required 0", tri_ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (tri_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready_busy got=%0b/%0b required 1/0", tri_ready, busy);
    end
    n_cmp++;
    if (tri_count !== 16'd0 || vertex_dout !== '0 || color_dout !== '0) begin
      n_bad++; $display("FAIL reset_values count=%0d vdout=%0h cdout=%0h required 0/0/0", tri_count, vertex_dout, color_dout);
    end
    repeat (10) begin @(posedge clk); #1; end
    n_cmp++;
    if (obs_v.size() != 0) begin n_bad++; $display("FAIL reset_idle_strobes got=%0d required 0", obs_v.size()); end
  endtask

  task automatic test_single();
    clear_sb();
    send_tri(96'hA1, 96'hA2, 96'hA3, 96'hC1, 96'hC2, 96'hC3);
    n_cmp++;
    if (busy !== 1'b1 || tri_ready !== 1'b0) begin n_bad++; $display("FAIL single_busy_after_accept got=%0b/%0b required 1/0", busy, tri_ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (tri_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_early got=%0b required 0", tri_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (tri_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_return got=%0b required 1", tri_ready); end
    n_cmp++;
    if (tri_count !== 16'd1) begin n_bad++; $display("FAIL single_count got=%0d required 1", tri_count); end
    n_cmp++;
    if (obs_v.size() != 3 || obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[1] + 1) begin
      n_bad++; $display("FAIL single_beats_consecutive got=%0d beats required 3 consecutive", obs_v.size());
    end
    while (exp_v.size() > 0 && obs_v.size() > 0) begin
      logic [DW-1:0] ev, ec, ov, oc;
      ev = exp_v.pop_front(); ec = exp_c.pop_front(); ov = obs_v.pop_front(); oc = obs_c.pop_front();
      n_cmp++;
      if (ov !== ev || oc !== ec) begin n_bad++; $display("FAIL single_data got=%0h/%0h required %0h/%0h", ov, oc, ev, ec); end
    end
  endtask

  task automatic test_stall();
    clear_sb();
    send_tri(96'hB1, 96'hB2, 96'hB3, 96'hD1, 96'hD2, 96'hD3);
    @(posedge clk); #1;
    color_full = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (vertex_wr_en !== 1'b0 || color_wr_en !== 1'b0 || vertex_dout !== 96'hB2 || color_dout !== 96'hD2) begin
        n_bad++;
        $display("FAIL stall_hold cycle=%0d we=%0b/%0b dout=%0h/%0h required 0/0 b2/d2", i, vertex_wr_en, color_wr_en, vertex_dout, color_dout);
      end
      @(posedge clk); #1;
    end
    color_full = 1'b0;
    wait_idle();
    n_cmp++;
    if (obs_v.size() != 3) begin n_bad++; $display("FAIL stall_beat_count got=%0d required 3", obs_v.size()); end
    n_cmp++;
    if (tri_count !== 16'd2) begin n_bad++; $display("FAIL stall_count got=%0d required 2", tri_count); end
    while (exp_v.size() > 0 && obs_v.size() > 0) begin
      logic [DW-1:0] ev, ec, ov, oc;
      ev = exp_v.pop_front(); ec = exp_c.pop_front(); ov = obs_v.pop_front(); oc = obs_c.pop_front();
      n_cmp++;
      if (ov !== ev || oc !== ec) begin n_bad++; $display("FAIL stall_data got=%0h/%0h required %0h/%0h", ov, oc, ev, ec); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] base;
    clear_sb();
    base = tri_count;
    tri_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      int n = 0;
      while (!tri_ready && n < 100) begin
        vertex_in0 = {$urandom, $urandom, $urandom}; color_in2 = {$urandom, $urandom, $urandom};
        @(posedge clk); #1; n++;
      end
      vertex_in0 = DW'(16'h1000 + t); vertex_in1 = DW'(16'h1100 + t); vertex_in2 = DW'(16'h1200 + t);
      color_in0 = DW'(16'h2000 + t); color_in1 = DW'(16'h2100 + t); color_in2 = DW'(16'h2200 + t);
      exp_v.push_back(vertex_in0); exp_v.push_back(vertex_in1); exp_v.push_back(vertex_in2);
      exp_c.push_back(color_in0); exp_c.push_back(color_in1); exp_c.push_back(color_in2);
      @(posedge clk); #1;
      vertex_in1 = '1; color_in1 = '1; vertex_in0 = 96'hDEAD;
    end
    tri_valid = 1'b0;
    wait_idle();
    n_cmp++;
    if (obs_v.size() != 12) begin n_bad++; $display("FAIL b2b_beat_count got=%0d required 12", obs_v.size()); end
    n_cmp++;
    if (tri_count !== base + 16'd4) begin n_bad++; $display("FAIL b2b_count got=%0d required %0d", tri_count, base + 16'd4); end
    n_cmp++;
    if (strobe_split != 0) begin n_bad++; $display("FAIL strobe_split got=%0d required 0", strobe_split); end
    while (exp_v.size() > 0 && obs_v.size() > 0) begin
      logic [DW-1:0] ev, ec, ov, oc;
      ev = exp_v.pop_front(); ec = exp_c.pop_front(); ov = obs_v.pop_front(); oc = obs_c.pop_front();
      n_cmp++;
      if (ov !== ev || oc !== ec) begin n_bad++; $display("FAIL b2b_data got=%0h/%0h required %0h/%0h", ov, oc, ev, ec); end
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    send_tri(96'hE1, 96'hE2, 96'hE3, 96'hF1, 96'hF2, 96'hF3);
    void'(exp_v.pop_back()); void'(exp_v.pop_back());
    void'(exp_c.pop_back()); void'(exp_c.pop_back());
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (tri_ready !== 1'b0 || vertex_wr_en !== 1'b0) begin n_bad++; $display("FAIL midrst_in_rst ready=%0b we=%0b required 0/0", tri_ready, vertex_wr_en); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (tri_ready !== 1'b1 || tri_count !== 16'd0 || w_count !== 2'd0) begin
      n_bad++; $display("FAIL midrst_after ready=%0b count=%0d wcount=%0d required 1/0/0", tri_ready, tri_count, w_count);
    end
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++;
    if (obs_v.size() != 1) begin n_bad++; $display("FAIL midrst_beats got=%0d required 1", obs_v.size()); end
    send_tri(96'h71, 96'h72, 96'h73, 96'h81, 96'h82, 96'h83);
    wait_idle();
    n_cmp++;
    if (obs_v.size() != 4 || tri_count !== 16'd1) begin n_bad++; $display("FAIL midrst_new_tri beats=%0d count=%0d required 4/1", obs_v.size(), tri_count); end
    while (exp_v.size() > 0 && obs_v.size() > 0) begin
      logic [DW-1:0] ev, ec, ov, oc;
      ev = exp_v.pop_front(); ec = exp_c.pop_front(); ov = obs_v.pop_front(); oc = obs_c.pop_front();
      n_cmp++;
      if (ov !== ev || oc !== ec) begin n_bad++; $display("FAIL midrst_data got=%0h/%0h required %0h/%0h", ov, oc, ev, ec); end
    end
  endtask

  task automatic test_count_wrap();
    logic [1:0] seq [5];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
    clear_sb();
    do_reset();
    for (int t = 0; t < 5; t++) begin
      send_tri(DW'(t), DW'(t + 10), DW'(t + 20), DW'(t + 30), DW'(t + 40), DW'(t + 50));
      wait_idle();
      n_cmp++;
      if (w_count !== seq[t]) begin n_bad++; $display("FAIL wrap_count tri=%0d got=%0d required %0d", t, w_count, seq[t]); end
    end
    n_cmp++;
    if (tri_count !== 16'd5) begin n_bad++; $display("FAIL wrap_wide_count got=%0d required 5", tri_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
